// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative 32-bit multiply/divide unit for the EX stage.
// Multiply is shift-add and divide is restoring, each retiring one bit per cycle.
// FSM: IDLE -> RUN -> FIX -> DONE. busy is high in RUN and FIX, and done pulses for one cycle in DONE.
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies leave RUN once the shifted
// multiplier has no set bits left. Divides always take the full iteration count.
module ex_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A_ex,
   input  logic [WIDTH-1:0] B_ex,
   input  logic [4:0]       Ri_ex,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [4:0]       rd_tag,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef MULDIV_EARLY_OUT_EN
   localparam logic EARLY_OUT = 1'b1;
`else
   localparam logic EARLY_OUT = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Two's-complement negation of an operand-width value
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
      return (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // Two's-complement negation of a double-width value
   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
      return (~x) + {{(2*WIDTH-1){1'b0}}, 1'b1};
   endfunction

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;      // product, or remainder:quotient
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;  // shifted multiplicand; divisor in low half
   logic [WIDTH-1:0]     mplr_q, mplr_d;    // remaining multiplier magnitude
   logic [WIDTH-1:0]     a_raw_q, a_raw_d;  // dividend as presented, for divide-by-zero
   logic [1:0]           op_q, op_d;
   logic                 neg_res_q, neg_res_d;
   logic                 neg_a_q, neg_a_d;
   logic                 bz_q, bz_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic [4:0]           rd_tag_q, rd_tag_d;
   logic                 dbz_q, dbz_d;

   logic                 accept_s;
   logic                 last_s;
   logic [WIDTH-1:0]     a_mag_s, b_mag_s;
   logic [WIDTH-1:0]     mplr_nx_s;
   logic [2*WIDTH-1:0]   mul_acc_s;
   logic [WIDTH:0]       sh_rem_s, trial_s;
   logic [2*WIDTH-1:0]   div_acc_s;

   assign accept_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));

   // Per-iteration arithmetic and the accept-time operand magnitudes
   always_comb begin
      a_mag_s   = (op[0] && A_ex[WIDTH-1]) ? neg_w(A_ex) : A_ex;
      b_mag_s   = (op[0] && B_ex[WIDTH-1]) ? neg_w(B_ex) : B_ex;
      mplr_nx_s = {1'b0, mplr_q[WIDTH-1:1]};
      mul_acc_s = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
      sh_rem_s  = acc_q[2*WIDTH-1:WIDTH-1];
      trial_s   = sh_rem_s - {1'b0, mcand_q[WIDTH-1:0]};
      div_acc_s = trial_s[WIDTH] ? {sh_rem_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {trial_s[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
      last_s    = (cnt_q == CNT_LAST) ||
                  (EARLY_OUT && !op_q[1] && (mplr_nx_s == {WIDTH{1'b0}}));
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = accept_s ? S_RUN : S_IDLE;
         S_RUN:   state_d = last_s ? S_FIX : S_RUN;
         S_FIX:   state_d = S_DONE;
         S_DONE:  state_d = accept_s ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs, registered from the next state so busy/done leave flops
   always_comb begin
      busy_d = (state_d == S_RUN) || (state_d == S_FIX);
      done_d = (state_d == S_DONE);
   end

   // Datapath next-state: operand latch on accept, one iteration per RUN cycle, sign fix-up in FIX
   always_comb begin
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      a_raw_d   = a_raw_q;
      op_d      = op_q;
      neg_res_d = neg_res_q;
      neg_a_d   = neg_a_q;
      bz_d      = bz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      rd_tag_d  = rd_tag_q;
      dbz_d     = dbz_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept_s) begin
               cnt_d     = {CNT_W{1'b0}};
               op_d      = op;
               rd_tag_d  = Ri_ex;
               a_raw_d   = A_ex;
               mplr_d    = b_mag_s;
               neg_res_d = op[0] & (A_ex[WIDTH-1] ^ B_ex[WIDTH-1]);
               neg_a_d   = op[0] & A_ex[WIDTH-1];
               bz_d      = (B_ex == {WIDTH{1'b0}});
               if (op[1]) begin
                  acc_d   = {{WIDTH{1'b0}}, a_mag_s};
                  mcand_d = {{WIDTH{1'b0}}, b_mag_s};
               end else begin
                  acc_d   = {(2*WIDTH){1'b0}};
                  mcand_d = {{WIDTH{1'b0}}, a_mag_s};
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + CNT_ONE;
            if (op_q[1]) begin
               acc_d = div_acc_s;
            end else begin
               acc_d   = mul_acc_s;
               mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
               mplr_d  = mplr_nx_s;
            end
         end
         S_FIX: begin
            if (op_q[1]) begin
               if (bz_q) begin
                  lo_d  = {WIDTH{1'b1}};
                  hi_d  = a_raw_q;
                  dbz_d = 1'b1;
               end else begin
                  lo_d  = neg_res_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
                  hi_d  = neg_a_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
                  dbz_d = 1'b0;
               end
            end else begin
               {hi_d, lo_d} = neg_res_q ? neg_2w(acc_q) : acc_q;
               dbz_d        = 1'b0;
            end
         end
         default: begin
            cnt_d = cnt_q;
         end
      endcase
   end

   // Datapath and output registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= {CNT_W{1'b0}};
         acc_q     <= {(2*WIDTH){1'b0}};
         mcand_q   <= {(2*WIDTH){1'b0}};
         mplr_q    <= {WIDTH{1'b0}};
         a_raw_q   <= {WIDTH{1'b0}};
         op_q      <= 2'd0;
         neg_res_q <= 1'b0;
         neg_a_q   <= 1'b0;
         bz_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= {WIDTH{1'b0}};
         lo_q      <= {WIDTH{1'b0}};
         rd_tag_q  <= 5'd0;
         dbz_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplr_q    <= mplr_d;
         a_raw_q   <= a_raw_d;
         op_q      <= op_d;
         neg_res_q <= neg_res_d;
         neg_a_q   <= neg_a_d;
         bz_q      <= bz_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         rd_tag_q  <= rd_tag_d;
         dbz_q     <= dbz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign rd_tag      = rd_tag_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: expected results are pushed at accept and
// compared (values and exact done cycle) when done pulses.
// Honours MULDIV_EARLY_OUT_EN for expected multiply latency.
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] a_ex = 32'd0;
   logic [31:0] b_ex = 32'd0;
   logic [4:0]  ri_ex = 5'd0;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;
   logic [4:0]  rd_tag;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      logic [4:0]  tag;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   ex_muldiv #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .A_ex(a_ex), .B_ex(b_ex), .Ri_ex(ri_ex),
      .busy(busy), .done(done), .hi(hi), .lo(lo),
      .rd_tag(rd_tag), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int latency(input logic [1:0] o, input logic [31:0] b);
      int bl;
      logic [31:0] m;
      bl = 0;
      m  = (o[0] && b[31]) ? (32'd0 - b) : b;
      for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
      if (bl < 1) bl = 1;
`ifdef MULDIV_EARLY_OUT_EN
      if (!o[1]) return bl + 2;
`endif
      return 34;
   endfunction

   task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] ehi, output logic [31:0] elo, output logic edbz);
      longint          sa, sb, sp, q, r;
      longint unsigned ua, ub, up;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      edbz = 1'b0;
      case (o)
         2'd0: begin up = ua * ub; ehi = up[63:32]; elo = up[31:0]; end
         2'd1: begin sp = sa * sb; ehi = sp[63:32]; elo = sp[31:0]; end
         2'd2: begin
            if (b == 32'd0) begin elo = 32'hFFFF_FFFF; ehi = a; edbz = 1'b1; end
            else begin elo = a / b; ehi = a % b; end
         end
         default: begin
            if (b == 32'd0) begin elo = 32'hFFFF_FFFF; ehi = a; edbz = 1'b1; end
            else begin q = sa / sb; r = sa % sb; elo = q[31:0]; ehi = r[31:0]; end
         end
      endcase
   endtask

   task automatic push_exp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] t, input int acc);
      exp_t e;
      model(o, a, b, e.hi, e.lo, e.dbz);
      e.tag = t;
      e.cyc = acc + latency(o, b) - 1;
      sb_q.push_back(e);
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t);
      int w;
      w = 0;
      @(negedge clk);
      while (busy && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (busy) chk("issue_wait", 64'd1, 64'd0);
      op = o; a_ex = a; b_ex = b; ri_ex = t; start = 1'b1;
      @(posedge clk);
      #1;
      push_exp(o, a, b, t, cyc);
      chk("accept_busy", 64'(busy), 64'd1);
      chk("accept_tag", 64'(rd_tag), 64'(t));
      start = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb_q.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("drain_empty", 64'(sb_q.size()), 64'd0);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_hi"}, 64'(hi), 64'd0);
      chk({tag, "_lo"}, 64'(lo), 64'd0);
      chk({tag, "_tag"}, 64'(rd_tag), 64'd0);
      chk({tag, "_dbz"}, 64'(div_by_zero), 64'd0);
   endtask

   // Scoreboard monitor: compare each done pulse, flag missing or spurious pulses
   always @(negedge clk) begin
      if (done) begin
         if (sb_q.size() == 0) begin
            chk("spurious_done", 64'd1, 64'd0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
            chk("hi", 64'(hi), 64'(mon_e.hi));
            chk("lo", 64'(lo), 64'(mon_e.lo));
            chk("div_by_zero", 64'(div_by_zero), 64'(mon_e.dbz));
            chk("rd_tag", 64'(rd_tag), 64'(mon_e.tag));
            chk("busy_in_done", 64'(busy), 64'd0);
         end
      end else if (sb_q.size() != 0 && cyc > sb_q[0].cyc) begin
         chk("done_missing", 64'd0, 64'd1);
         void'(sb_q.pop_front());
      end
   end

   initial begin
      int acc1;
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      #12;
      chk_zero_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1); drain();
      issue(2'd1, 32'hFFFF_FFFD, 32'd7,         5'd2); drain();
      issue(2'd3, 32'hFFFF_FFF9, 32'd2,         5'd3); drain();
      issue(2'd2, 32'd100,       32'd0,         5'd4); drain();
      issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5); drain();
      issue(2'd3, 32'hFFFF_FFF9, 32'd0,         5'd6); drain();
      issue(2'd0, 32'd5,         32'd1,         5'd7); drain();
      issue(2'd1, 32'h8000_0000, 32'h8000_0000, 5'd8); drain();

      // random ops issued as soon as the unit frees up (often back-to-back)
      for (int i = 0; i < 8; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
         issue(ro, ra, rb, 5'(16 + i));
      end
      drain();

      // reset in the middle of a divide: outputs clear at once, no done follows
      issue(2'd2, 32'd1000, 32'd3, 5'd10);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_zero_outputs("midreset");
      sb_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      issue(2'd0, 32'd6, 32'd7, 5'd11); drain();

      // start held high: ignored in RUN/FIX, second op taken in the DONE cycle
      @(negedge clk);
      op = 2'd2; a_ex = 32'd1000; b_ex = 32'd7; ri_ex = 5'd12; start = 1'b1;
      @(posedge clk);
      #1;
      acc1 = cyc;
      push_exp(2'd2, 32'd1000, 32'd7, 5'd12, acc1);
      op = 2'd1; a_ex = 32'hFFFF_FFFD; b_ex = 32'd7; ri_ex = 5'd13;
      repeat (34) @(posedge clk);
      #1;
      push_exp(2'd1, 32'hFFFF_FFFD, 32'd7, 5'd13, acc1 + 34);
      start = 1'b0;
      chk("hold_accept_tag", 64'(rd_tag), 64'd13);
      drain();

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      chk("global_timeout", 64'd0, 64'd1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "time limit reached");
   end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit on the execute side of the ID/EX pipeline register; consumes the registered operands, opcode class and destination register tag that ID/EX presents to EX. Performs 32-bit signed/unsigned multiply (64-bit product) and divide (quotient plus remainder) one bit per cycle. Holds `busy` so pipeline control can stall IF/ID/ID_EX. Publishes the result on `hi`/`lo` with a one-cycle `done` pulse carrying the latched destination tag.

## Interface
- `WIDTH`, 32: operand width; the iteration count equals `WIDTH`.
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; `op_ex` decodes to a mul/div class this cycle.
- `op`  in  2  00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed).
- `A_ex`  in  WIDTH  multiplicand / dividend.
- `B_ex`  in  WIDTH  multiplier / divisor.
- `Ri_ex`  in  5  destination register tag.
- `busy`  out  1  high in RUN and FIX.
- `done`  out  1  one-cycle pulse, result valid.
- `hi`  out  WIDTH  product[63:32] / remainder.
- `lo`  out  WIDTH  product[31:0] / quotient.
- `rd_tag`  out  5  tag latched at accept.
- `div_by_zero`  out  1  valid with `done`; set for divide with `B_ex`=0.

## Operation
- FSM: IDLE -> RUN -> FIX -> DONE -> IDLE.
- Accept: `start` sampled high in IDLE or DONE. Latch `op`, `Ri_ex`, operand magnitudes (two's-complement abs for signed ops) and the result signs. Enter RUN with counter = 0.
- `start` in RUN or FIX is ignored; no queueing.
- RUN, multiply: shift-add on 2×WIDTH accumulator, multiplier shifted right one bit per cycle.
- RUN, divide: restoring; shift remainder:quotient left, trial subtract, set quotient bit.
- Counter increments each RUN cycle. Exit to FIX after iteration 31.
- FIX: apply signs. Signed multiply negates the 64-bit product when the signs differ. Signed divide negates the quotient when sign(A) ≠ sign(B) and gives the remainder the sign of A. Register `hi`/`lo`/`div_by_zero`.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- Divide by zero runs the full latency: `lo`=0xFFFFFFFF, `hi`=`A_ex` as latched (signed ops: original A), `div_by_zero`=1.
- DONE: `done`=1, `busy`=0.
- `hi`/`lo`/`rd_tag`/`div_by_zero` hold their values until the next FIX or accept.

## Timing
- Reset (async assert): state IDLE; `busy`, `done`, `div_by_zero` = 0; `hi`, `lo` = 0; `rd_tag` = 0. Internal accumulators and counter are cleared.
- Reset mid-operation aborts the operation with no `done`. First accept is possible on the first edge after deassertion.
- Start accepted at edge E0 gives: RUN on edges E1..E32, FIX on edge E33, `done` high in the cycle between E33 and E34.
- `busy` is high from after E0 until E33.
- Back-to-back: `start` in the DONE cycle is accepted at E34, so the next `done` follows 34 cycles later.
- `rd_tag` is updated at accept, so it changes at E0 and is stable through `done`.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined: multiply ops leave RUN after the iteration in which the remaining shifted multiplier magnitude becomes zero (minimum 1 RUN cycle). Latency is bitlen(|B|)+2 edges to `done`, minimum 3. Divide is unaffected.
- Undefined: fixed 32 RUN cycles for all ops.

## Test plan
- MULU 0xFFFFFFFF×0xFFFFFFFF -> `done` at E0+34, `hi`=0xFFFFFFFE, `lo`=0x00000001, `busy` low in the `done` cycle.
- MUL −3×7 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. DIV −7/2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF, `rd_tag` equals the tag given at accept.
- DIVU 100/0 -> `lo`=0xFFFFFFFF, `hi`=100, `div_by_zero`=1 at E0+34. DIV 0x80000000/0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- `rst_n` pulsed low at E0+10 of a DIVU -> all outputs 0 immediately, no `done`. A new MULU 6×7 accepted after reset -> `lo`=42.
- `start` held throughout: ignored during RUN/FIX. A second op is accepted in the DONE cycle, producing exactly two `done` pulses 34 cycles apart.
- With `MULDIV_EARLY_OUT_EN`: MULU 5×1 -> `done` at E0+3, `lo`=5. Without it: same op -> `done` at E0+34.
